// File: rtl/gate_vector_sequencer.sv
`timescale 1ns/1ps
// Self-test sequencer for the and/or/nand/nor gate bank: sweeps (a,b) through 00..11 and checks responses.
// Optional GATE_SEQ_FIRST_FAIL_EN adds capture of the first mismatching vector/response of a run.
module gate_vector_sequencer #(
   parameter int HOLD_CYCLES = 2,
   parameter int PASSES      = 1,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_out,
   output logic             b_out,
   input  logic             and_y,
   input  logic             or_y,
   input  logic             nand_y,
   input  logic             nor_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef GATE_SEQ_FIRST_FAIL_EN
   output logic [1:0]       fail_vec,
   output logic [3:0]       fail_resp,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_vec, w_vec_nxt;
   logic [HW-1:0]    r_hold, w_hold_nxt;
   logic [PW-1:0]    r_pcnt, w_pcnt_nxt;
   logic [ERR_W-1:0] r_err, w_err_nxt;
   logic             r_pass, w_pass_nxt;
   logic             r_done, w_done_nxt;
   logic             r_busy, w_busy_nxt;
   logic [3:0]       w_exp, w_resp;
   logic             w_miss, w_cmp;
`ifdef GATE_SEQ_FIRST_FAIL_EN
   logic [1:0]       r_fvec, w_fvec_nxt;
   logic [3:0]       r_fresp, w_fresp_nxt;
`endif

   assign w_exp  = {&r_vec, |r_vec, ~(&r_vec), ~(|r_vec)};
   assign w_resp = {and_y, or_y, nand_y, nor_y};
   assign w_miss = (w_resp != w_exp);
   assign w_cmp  = (r_state == S_DRIVE) && (r_hold == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_hold_nxt  = r_hold;
      w_pcnt_nxt  = r_pcnt;
      w_err_nxt   = r_err;
      w_pass_nxt  = r_pass;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      w_fvec_nxt  = r_fvec;
      w_fresp_nxt = r_fresp;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_DRIVE;
               w_vec_nxt   = 2'd0;
               w_hold_nxt  = '0;
               w_pcnt_nxt  = '0;
               w_err_nxt   = '0;
               w_pass_nxt  = 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
               w_fvec_nxt  = 2'd0;
               w_fresp_nxt = 4'd0;
`endif
            end
         end
         S_DRIVE: begin
            if (w_cmp) begin
               w_hold_nxt = '0;
               w_vec_nxt  = r_vec + 2'd1;
               if (w_miss) begin
                  w_err_nxt = (r_err == ERR_MAX) ? r_err : r_err + 1'b1;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                  // err_cnt still zero means this is the run's first mismatch
                  if (r_err == '0) begin
                     w_fvec_nxt  = r_vec;
                     w_fresp_nxt = w_resp;
                  end
`endif
               end
               if (r_vec == 2'd3) begin
                  if (r_pcnt == PASS_LAST) begin
                     w_state_nxt = S_DONE;
                     w_pass_nxt  = (w_err_nxt == '0);
                  end else begin
                     w_pcnt_nxt = r_pcnt + 1'b1;
                  end
               end
            end else begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_DRIVE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec   <= 2'd0;
         r_hold  <= '0;
         r_pcnt  <= '0;
         r_err   <= '0;
         r_pass  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
         r_fvec  <= 2'd0;
         r_fresp <= 4'd0;
`endif
      end else begin
         r_vec   <= w_vec_nxt;
         r_hold  <= w_hold_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_err   <= w_err_nxt;
         r_pass  <= w_pass_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
`ifdef GATE_SEQ_FIRST_FAIL_EN
         r_fvec  <= w_fvec_nxt;
         r_fresp <= w_fresp_nxt;
`endif
      end
   end

   // vec wraps to 0 on the final compare, so a/b return low at run end
   assign a_out   = r_vec[1];
   assign b_out   = r_vec[0];
   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign err_cnt = r_err;
`ifdef GATE_SEQ_FIRST_FAIL_EN
   assign fail_vec  = r_fvec;
   assign fail_resp = r_fresp;
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
`timescale 1ns/1ps
// Bench for gate_vector_sequencer: two instances (H=2,P=1,E=4 and H=1,P=5,E=2) driven by a faultable gate bank.
module tb_gate_vector_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       st [2];
   logic       a_o [2], b_o [2], bsy [2], dn [2], ps [2];
   logic [3:0] rsp [2];
   logic [3:0] msk [2][4];
   logic [3:0] errA;
   logic [1:0] errB;
`ifdef GATE_SEQ_FIRST_FAIL_EN
   logic [1:0] fvA, fvB;
   logic [3:0] frA, frB;
`endif
   int n_chk = 0;
   int n_pass = 0;

   function automatic logic [3:0] gold(input logic a, input logic b);
      return {a & b, a | b, ~(a & b), ~(a | b)};
   endfunction

   // gate bank: ideal truth table with a per-vector fault mask flipping response bits
   assign rsp[0] = gold(a_o[0], b_o[0]) ^ msk[0][{a_o[0], b_o[0]}];
   assign rsp[1] = gold(a_o[1], b_o[1]) ^ msk[1][{a_o[1], b_o[1]}];

   gate_vector_sequencer #(.HOLD_CYCLES(2), .PASSES(1), .ERR_W(4)) u_a (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .a_out(a_o[0]), .b_out(b_o[0]),
      .and_y(rsp[0][3]), .or_y(rsp[0][2]), .nand_y(rsp[0][1]), .nor_y(rsp[0][0]),
      .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
`ifdef GATE_SEQ_FIRST_FAIL_EN
      .fail_vec(fvA), .fail_resp(frA),
`endif
      .err_cnt(errA));

   gate_vector_sequencer #(.HOLD_CYCLES(1), .PASSES(5), .ERR_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .a_out(a_o[1]), .b_out(b_o[1]),
      .and_y(rsp[1][3]), .or_y(rsp[1][2]), .nand_y(rsp[1][1]), .nor_y(rsp[1][0]),
      .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
`ifdef GATE_SEQ_FIRST_FAIL_EN
      .fail_vec(fvB), .fail_resp(frB),
`endif
      .err_cnt(errB));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] err_of(input int i);
      return (i != 0) ? {30'd0, errB} : {28'd0, errA};
   endfunction

   // errors after k cycles of a run: one compare every H cycles, vector index = compare number mod 4
   function automatic int exp_err(input int i, input int k, input int h, input int maxe);
      int c = 0;
      for (int j = 1; j <= k / h; j++)
         if (msk[i][(j - 1) % 4] != 4'd0) c++;
      return (c > maxe) ? maxe : c;
   endfunction

   task automatic clr_masks();
      for (int i = 0; i < 2; i++)
         for (int v = 0; v < 4; v++) msk[i][v] = 4'd0;
   endtask

   task automatic run(input int i, input bit spam);
      int h, p, maxe, n, tot, vi;
      logic [1:0] vv;
      h = (i != 0) ? 1 : 2;
      p = (i != 0) ? 5 : 1;
      maxe = (i != 0) ? 3 : 15;
      n = 4 * p * h;
      tot = exp_err(i, n, h, 1 << 30);
      @(negedge clk);
      st[i] = 1'b1;
      for (int k = 0; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (k == n || !spam) st[i] = 1'b0;
         vi = (k < n) ? (k / h) % 4 : 0;
         vv = vi[1:0];
         chk($sformatf("a_out i%0d k%0d", i, k), a_o[i], vv[1]);
         chk($sformatf("b_out i%0d k%0d", i, k), b_o[i], vv[0]);
         chk($sformatf("busy i%0d k%0d", i, k), bsy[i], (k < n));
         chk($sformatf("done i%0d k%0d", i, k), dn[i], (k == n));
         chk($sformatf("err_cnt i%0d k%0d", i, k), err_of(i), exp_err(i, k, h, maxe));
         chk($sformatf("pass i%0d k%0d", i, k), ps[i], (k == n) && (tot == 0));
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("done_after i%0d", i), dn[i], 1'b0);
         chk($sformatf("pass_hold i%0d", i), ps[i], (tot == 0));
         chk($sformatf("err_hold i%0d", i), err_of(i), (tot > maxe) ? maxe : tot);
      end
`ifdef GATE_SEQ_FIRST_FAIL_EN
      begin
         logic [1:0] efv;
         logic [3:0] efr;
         efv = 2'd0;
         efr = 4'd0;
         for (int j = 4 * p; j >= 1; j--) begin
            vi = (j - 1) % 4;
            if (msk[i][vi] != 4'd0) begin
               efv = vi[1:0];
               efr = gold(efv[1], efv[0]) ^ msk[i][vi];
            end
         end
         chk($sformatf("fail_vec i%0d", i), (i != 0) ? fvB : fvA, efv);
         chk($sformatf("fail_resp i%0d", i), (i != 0) ? frB : frA, efr);
      end
`endif
   endtask

   task automatic chk_zero(input string tag, input int i);
      chk({tag, " a_out"}, a_o[i], 1'b0);
      chk({tag, " b_out"}, b_o[i], 1'b0);
      chk({tag, " busy"}, bsy[i], 1'b0);
      chk({tag, " done"}, dn[i], 1'b0);
      chk({tag, " pass"}, ps[i], 1'b0);
      chk({tag, " err_cnt"}, err_of(i), 0);
   endtask

   initial begin
      st[0] = 1'b0;
      st[1] = 1'b0;
      clr_masks();
      #12;
      chk_zero("reset A", 0);
      chk_zero("reset B", 1);
      @(negedge clk);
      rst_n = 1'b1;

      run(0, 1'b0);                          // clean bank
      msk[0][3] = 4'b1000;                   // and_y forced 0 only shows at vector 11
      run(0, 1'b0);
      clr_masks();
      run(0, 1'b1);                          // start held high through the run

      // async reset mid-run aborts without a done pulse
      @(negedge clk);
      st[0] = 1'b1;
      @(posedge clk);
      #1 st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_zero("midrun reset A", 0);
      @(posedge clk);
      #1 chk("midrun reset done", dn[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 1'b0);

      run(1, 1'b0);                          // one-cycle hold, five passes
      msk[1][0] = 4'b0001;                   // nor_y stuck 0: one error per pass, saturates at 3
      run(1, 1'b0);
      clr_masks();

      for (int r = 0; r < 8; r++) begin
         int i;
         i = int'($urandom_range(0, 1));
         for (int v = 0; v < 4; v++)
            msk[i][v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         run(i, 1'($urandom_range(0, 1)));
         clr_masks();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
endmodule
